axi4_lite_master_queued: RTL and testbench

Parametrised AXI4-Lite master that replaces the single-shot enable-driven master with a queued command/response interface. User logic pushes read/write commands into an internal FIFO; the block issues them one at a time on the AXI4-Lite channels, with AW and W driven concurrently, and returns each result on a valid/ready response port. A per-transaction timeout converts a hung slave into a flagged error response.

---
 rtl/axi4_lite_master_queued_if.sv | 28 ++
 rtl/axi4_lite_master_queued.sv | 188 ++++++++++++++++++
 tb/tb_axi4_lite_master_queued.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_queued_if.sv
// AXI4-Lite bus bundle for the queued master: five channels, master/slave views.
interface axi4_lite_master_queued_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                       awvalid, awready;
  logic [ADDRESS_WIDTH-1:0]   awaddr;
  logic                       wvalid, wready;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [DATA_WIDTH/8-1:0]    wstrb;
  logic                       bvalid, bready;
  logic [1:0]                 bresp;
  logic                       arvalid, arready;
  logic [ADDRESS_WIDTH-1:0]   araddr;
  logic                       rvalid, rready;
  logic [DATA_WIDTH-1:0]      rdata;
  logic [1:0]                 rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_master_queued.sv
// Queued AXI4-Lite master: command FIFO feeding a one-at-a-time AXI FSM with
// a valid/ready response port and a per-transaction timeout.
module axi4_lite_master_queued #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_wstrb,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_write,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [1:0]                       rsp_resp,
  output logic                             rsp_timeout,
  output logic [$clog2(CMD_DEPTH+1)-1:0]   cmd_level,
  output logic                             busy,
  output logic                             timeout_err,
  axi4_lite_master_queued_if.master        axi
);
  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int LVL_W = $clog2(CMD_DEPTH+1);
  localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH/8-1:0]  wstrb;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t            state;
  cmd_t              mem [CMD_DEPTH];
  cmd_t              head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [TW-1:0]     tcnt;
  logic              full, empty, push, pop;
  logic              active, xfer_done, tmo_hit, tmo_fire;

  assign full      = (count == LVL_W'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = ~rst & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) & ~empty & ~timeout_err;
  assign head      = mem[rd_ptr];
  assign cmd_level = count;
  assign busy      = (state != IDLE);

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{cmd_write, cmd_addr, cmd_wdata, cmd_wstrb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign active = (state == WR_AW_W) | (state == WR_B) | (state == RD_AR) | (state == RD_R);

  // A handshake completing in the same cycle as the limit takes priority.
  always_comb begin
    xfer_done = 1'b0;
    case (state)
      WR_AW_W: xfer_done = (~axi.awvalid | axi.awready) & (~axi.wvalid | axi.wready);
      WR_B:    xfer_done = axi.bvalid;
      RD_AR:   xfer_done = axi.arready;
      RD_R:    xfer_done = axi.rvalid;
      default: xfer_done = 1'b0;
    endcase
  end

  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign tmo_fire = active & tmo_hit & ~xfer_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (active && tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
      if (tmo_fire) begin
        axi.awvalid <= 1'b0;
        axi.wvalid  <= 1'b0;
        axi.bready  <= 1'b0;
        axi.arvalid <= 1'b0;
        axi.rready  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_write   <= (state == WR_AW_W) | (state == WR_B);
        rsp_rdata   <= '0;
        rsp_resp    <= 2'b10;
        rsp_timeout <= 1'b1;
        timeout_err <= 1'b1;
        state       <= RSP;
      end else begin
        case (state)
          IDLE: if (pop) begin
            tcnt <= '0;
            if (head.write) begin
              axi.awaddr  <= head.addr;
              axi.wdata   <= head.wdata;
              axi.wstrb   <= head.wstrb;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= WR_AW_W;
            end else begin
              axi.araddr  <= head.addr;
              axi.arvalid <= 1'b1;
              state       <= RD_AR;
            end
          end
          WR_AW_W: begin
            if (axi.awready) axi.awvalid <= 1'b0;
            if (axi.wready)  axi.wvalid  <= 1'b0;
            if (xfer_done) begin
              axi.bready <= 1'b1;
              state      <= WR_B;
            end
          end
          WR_B: if (axi.bvalid) begin
            axi.bready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= axi.bresp;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
          RD_AR: if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= RD_R;
          end
          RD_R: if (axi.rvalid) begin
            axi.rready  <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b0;
            rsp_rdata   <= axi.rdata;
            rsp_resp    <= axi.rresp;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
          RSP: if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_master_queued.sv
// Directed bench for axi4_lite_master_queued; the slave side is driven by hand per scenario.
module tb_axi4_lite_master_queued;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy, timeout_err;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [2:0]    cmd_level;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi4_lite_master_queued_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) axi ();

  axi4_lite_master_queued #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .cmd_level(cmd_level), .busy(busy), .timeout_err(timeout_err), .axi(axi)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic serve_read(input logic [31:0] data, input logic [1:0] resp, output bit ok, output logic [31:0] addr);
    ok = 1'b0; addr = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (axi.arvalid) ok = 1'b1; else step();
    end
    if (!ok) return;
    addr = axi.araddr;
    axi.arready = 1'b1; step(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = data; axi.rresp = resp; step(); axi.rvalid = 1'b0;
  endtask

  task automatic serve_write(input logic [1:0] resp, output bit ok, output logic [31:0] addr, output logic [31:0] data);
    ok = 1'b0; addr = '0; data = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (axi.awvalid) ok = 1'b1; else step();
    end
    if (!ok) return;
    addr = axi.awaddr; data = axi.wdata;
    axi.awready = 1'b1; axi.wready = 1'b1; step(); axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b1; axi.bresp = resp; step(); axi.bvalid = 1'b0;
  endtask

  task automatic take_rsp(output bit ok, output logic [31:0] rdata, output logic [1:0] resp, output bit wr, output bit tmo);
    ok = 1'b0; rdata = '0; resp = '0; wr = 1'b0; tmo = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rsp_valid) ok = 1'b1; else step();
    end
    if (!ok) return;
    rdata = rsp_rdata; resp = rsp_resp; wr = rsp_write; tmo = rsp_timeout;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin errors++; $display("FAIL rst_axi_ctrl got=%b exp=00000", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}); end
    checks++; if ({rsp_valid, busy, timeout_err, cmd_level} !== 6'b0) begin errors++; $display("FAIL rst_status got=%b exp=000000", {rsp_valid, busy, timeout_err, cmd_level}); end
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got=%b exp=1", cmd_ready); end
    step();
  endtask

  task automatic test_single_write();
    push(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (cmd_level !== 3'd1) begin errors++; $display("FAIL wr_level got=%0d exp=1", cmd_level); end
    checks++; if (axi.awvalid !== 1'b0) begin errors++; $display("FAIL wr_early_awvalid got=%b exp=0", axi.awvalid); end
    step();
    checks++; if ({axi.awvalid, axi.wvalid} !== 2'b11) begin errors++; $display("FAIL wr_valids got=%b exp=11", {axi.awvalid, axi.wvalid}); end
    checks++; if (axi.awaddr !== 32'h10) begin errors++; $display("FAIL wr_awaddr got=%h exp=00000010", axi.awaddr); end
    checks++; if ({axi.wdata, axi.wstrb} !== {32'hDEADBEEF, 4'hF}) begin errors++; $display("FAIL wr_wdata got=%h exp=deadbeeff", {axi.wdata, axi.wstrb}); end
    axi.awready = 1'b1; axi.wready = 1'b1; step(); axi.awready = 1'b0; axi.wready = 1'b0;
    checks++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin errors++; $display("FAIL wr_b_phase got=%b exp=001", {axi.awvalid, axi.wvalid, axi.bready}); end
    axi.bvalid = 1'b1; axi.bresp = 2'b00; step(); axi.bvalid = 1'b0;
    checks++; if ({rsp_valid, rsp_write, rsp_resp, rsp_timeout} !== 5'b11000) begin errors++; $display("FAIL wr_rsp got=%b exp=11000", {rsp_valid, rsp_write, rsp_resp, rsp_timeout}); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata got=%h exp=0", rsp_rdata); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL wr_done got=%b exp=00", {rsp_valid, busy}); end
  endtask

  task automatic test_skewed_aw_w();
    push(1'b1, 32'h20, 32'h11223344, 4'h3);
    step();
    checks++; if ({axi.awvalid, axi.wvalid} !== 2'b11) begin errors++; $display("FAIL skew_start got=%b exp=11", {axi.awvalid, axi.wvalid}); end
    axi.wready = 1'b1; step(); axi.wready = 1'b0;
    checks++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin errors++; $display("FAIL skew_c1 got=%b exp=100", {axi.awvalid, axi.wvalid, axi.bready}); end
    step();
    checks++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin errors++; $display("FAIL skew_c2 got=%b exp=100", {axi.awvalid, axi.wvalid, axi.bready}); end
    step();
    checks++; if ({axi.awvalid, axi.bready} !== 2'b10) begin errors++; $display("FAIL skew_c3 got=%b exp=10", {axi.awvalid, axi.bready}); end
    axi.awready = 1'b1; step(); axi.awready = 1'b0;
    checks++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin errors++; $display("FAIL skew_b got=%b exp=001", {axi.awvalid, axi.wvalid, axi.bready}); end
    axi.bvalid = 1'b1; axi.bresp = 2'b10; step(); axi.bvalid = 1'b0;
    checks++; if ({rsp_valid, rsp_write, rsp_resp, axi.bready} !== 5'b11100) begin errors++; $display("FAIL skew_rsp got=%b exp=11100", {rsp_valid, rsp_write, rsp_resp, axi.bready}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_read_error();
    push(1'b0, 32'h40, 32'h0, 4'h0);
    step();
    checks++; if ({axi.arvalid, axi.awvalid} !== 2'b10) begin errors++; $display("FAIL rd_arvalid got=%b exp=10", {axi.arvalid, axi.awvalid}); end
    checks++; if (axi.araddr !== 32'h40) begin errors++; $display("FAIL rd_araddr got=%h exp=00000040", axi.araddr); end
    axi.arready = 1'b1; step(); axi.arready = 1'b0;
    checks++; if ({axi.arvalid, axi.rready} !== 2'b01) begin errors++; $display("FAIL rd_r_phase got=%b exp=01", {axi.arvalid, axi.rready}); end
    axi.rvalid = 1'b1; axi.rdata = 32'hCAFEF00D; axi.rresp = 2'b11; step(); axi.rvalid = 1'b0;
    checks++; if (rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_rdata got=%h exp=cafef00d", rsp_rdata); end
    checks++; if ({rsp_valid, rsp_write, rsp_resp, axi.rready} !== 5'b10110) begin errors++; $display("FAIL rd_rsp got=%b exp=10110", {rsp_valid, rsp_write, rsp_resp, axi.rready}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    bit ok, wr, tmo;
    logic [31:0] a, d;
    logic [1:0] r;
    push(1'b0, 32'h100, 32'h0, 4'h0);
    serve_read(32'hA0000100, 2'b00, ok, a);
    checks++; if (ok !== 1'b1 || a !== 32'h100) begin errors++; $display("FAIL full_first_ar ok=%b addr=%h exp ok=1 addr=00000100", ok, a); end
    for (int k = 1; k <= 4; k++) push(1'b0, 32'h100 + 32'(4 * k), 32'h0, 4'h0);
    checks++; if ({cmd_ready, cmd_level} !== 4'b0100) begin errors++; $display("FAIL full_level got ready=%b level=%0d exp ready=0 level=4", cmd_ready, cmd_level); end
    checks++; if (rsp_rdata !== 32'hA0000100) begin errors++; $display("FAIL full_rsp0 got=%h exp=a0000100", rsp_rdata); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h1F0;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_ready got=%b exp=0", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    checks++; if (cmd_level !== 3'd3) begin errors++; $display("FAIL full_no_bypass got=%0d exp=3", cmd_level); end
    for (int k = 1; k <= 4; k++) begin
      serve_read(32'hB0000100 + 32'(4 * k), 2'b00, ok, a);
      checks++; if (ok !== 1'b1 || a !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL full_order_ar%0d ok=%b addr=%h exp=%h", k, ok, a, 32'h100 + 32'(4 * k)); end
      take_rsp(ok, d, r, wr, tmo);
      checks++; if (ok !== 1'b1 || d !== 32'hB0000100 + 32'(4 * k)) begin errors++; $display("FAIL full_order_rsp%0d ok=%b data=%h exp=%h", k, ok, d, 32'hB0000100 + 32'(4 * k)); end
    end
    checks++; if ({cmd_level, busy} !== 4'b0000) begin errors++; $display("FAIL full_drained got level=%0d busy=%b exp 0 0", cmd_level, busy); end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    push(1'b0, 32'h200, 32'h0, 4'h0);
    push(1'b1, 32'h300, 32'h55, 4'hF);
    n = 0;
    while (axi.arvalid && n < 20) begin n++; step(); end
    checks++; if (n !== 8) begin errors++; $display("FAIL tmo_arvalid_cycles got=%0d exp=8", n); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_resp, rsp_write} !== 5'b11100) begin errors++; $display("FAIL tmo_rsp got=%b exp=11100", {rsp_valid, rsp_timeout, rsp_resp, rsp_write}); end
    checks++; if ({timeout_err, axi.rready} !== 2'b10) begin errors++; $display("FAIL tmo_err got=%b exp=10", {timeout_err, axi.rready}); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin seen = seen | axi.awvalid | axi.arvalid; step(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL tmo_blocked_issue got=%b exp=0", seen); end
    checks++; if ({cmd_level, busy, timeout_err} !== 5'b00101) begin errors++; $display("FAIL tmo_held got level=%0d busy=%b err=%b exp 1 0 1", cmd_level, busy, timeout_err); end
  endtask

  task automatic test_async_reset();
    bit ok, wr, tmo;
    logic [31:0] a, d;
    logic [1:0] r;
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    checks++; if ({timeout_err, cmd_level, cmd_ready} !== 5'b00001) begin errors++; $display("FAIL ar_clear got err=%b level=%0d ready=%b exp 0 0 1", timeout_err, cmd_level, cmd_ready); end
    step();
    push(1'b1, 32'h400, 32'hAAAA5555, 4'hF);
    push(1'b0, 32'h404, 32'h0, 4'h0);
    checks++; if ({axi.awvalid, cmd_level} !== 4'b1001) begin errors++; $display("FAIL ar_pre got aw=%b level=%0d exp 1 1", axi.awvalid, cmd_level); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({axi.awvalid, axi.wvalid, busy, rsp_valid, cmd_ready} !== 5'b0) begin errors++; $display("FAIL ar_async_outputs got=%b exp=00000", {axi.awvalid, axi.wvalid, busy, rsp_valid, cmd_ready}); end
    checks++; if (cmd_level !== 3'd0) begin errors++; $display("FAIL ar_async_level got=%0d exp=0", cmd_level); end
    #1 rst = 1'b0;
    step();
    checks++; if ({cmd_ready, axi.awvalid, axi.arvalid} !== 3'b100) begin errors++; $display("FAIL ar_after got=%b exp=100", {cmd_ready, axi.awvalid, axi.arvalid}); end
    push(1'b1, 32'h500, 32'h12345678, 4'hF);
    serve_write(2'b00, ok, a, d);
    checks++; if (ok !== 1'b1 || a !== 32'h500 || d !== 32'h12345678) begin errors++; $display("FAIL ar_new_write ok=%b addr=%h data=%h exp 1 00000500 12345678", ok, a, d); end
    take_rsp(ok, d, r, wr, tmo);
    checks++; if ({ok, r, wr, tmo} !== 5'b10010) begin errors++; $display("FAIL ar_new_rsp got=%b exp=10010", {ok, r, wr, tmo}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    test_reset();
    test_single_write();
    test_skewed_aw_w();
    test_read_error();
    test_fifo_full();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
